// File: rtl/data_bus_timer_resp.sv
// Data-bus slave with an LED register and a 64-bit machine timer with compare IRQ.
// Define DATA_BUS_TIMER_HI_LATCH_EN for a tear-free MTIME_HI read shadow.
module data_bus_timer_resp #(
  parameter int unsigned PrescaleDiv = 1,
  parameter int unsigned LedWidth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic                err_o,
  input  logic                we_i,
  input  logic [3:0]          be_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         wdata_i,
  output logic [31:0]         rdata_o,
  output logic [LedWidth-1:0] led_o,
  output logic                irq_timer_o
);

  localparam logic [15:0] PresMax = 16'(PrescaleDiv - 1);

  typedef enum logic [2:0] {
    OffLed    = 3'd0,
    OffCtrl   = 3'd1,
    OffMtLo   = 3'd2,
    OffMtHi   = 3'd3,
    OffCmpLo  = 3'd4,
    OffCmpHi  = 3'd5,
    OffStatus = 3'd6,
    OffNone   = 3'd7
  } off_e;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

  off_e off;
  logic wr;
  logic rd;
  logic tick;
  logic [31:0] hi_rd;

  logic [LedWidth-1:0] led_q, led_d;
  logic                en_q, en_d;
  logic [63:0]         mtime_q, mtime_d;
  logic [63:0]         cmp_q, cmp_d;
  logic [15:0]         presc_q, presc_d;
  logic                irq_q, irq_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic unused_addr;
  assign unused_addr = ^{addr_i[31:5], addr_i[1:0]};

  assign off = off_e'(addr_i[4:2]);
  assign wr  = req_i & we_i;
  assign rd  = req_i & ~we_i;

`ifdef DATA_BUS_TIMER_HI_LATCH_EN
  logic [31:0] shadow_q, shadow_d;

  assign hi_rd = shadow_q;

  always_comb begin
    shadow_d = shadow_q;
    if (rd && off == OffMtLo) begin
      shadow_d = mtime_q[63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`else
  assign hi_rd = mtime_q[63:32];
`endif

  always_comb begin
    tick    = en_q && (presc_q == PresMax);
    presc_d = presc_q;
    if (en_q) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
    end
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    led_d   = led_q;
    en_d    = en_q;
    cmp_d   = cmp_q;
    irq_d   = en_q && (mtime_q >= cmp_q);

    // A write to either MTIME half wins over the tick increment.
    if (wr) begin
      unique case (off)
        OffLed: begin
          for (int i = 0; i < int'(LedWidth); i++) begin
            led_d[i] = be_i[i/8] ? wdata_i[i] : led_q[i];
          end
        end
        OffCtrl:  en_d = be_i[0] ? wdata_i[0] : en_q;
        OffMtLo:  mtime_d = {mtime_q[63:32],
                             merge(mtime_q[31:0], wdata_i, be_i)};
        OffMtHi:  mtime_d = {merge(mtime_q[63:32], wdata_i, be_i),
                             mtime_q[31:0]};
        OffCmpLo: cmp_d[31:0] = merge(cmp_q[31:0], wdata_i, be_i);
        OffCmpHi: cmp_d[63:32] = merge(cmp_q[63:32], wdata_i, be_i);
        OffStatus: ;
        OffNone:   ;
      endcase
    end
  end

  always_comb begin
    rvalid_d = req_i;
    err_d    = req_i && (off == OffNone);
    rdata_d  = '0;
    if (rd) begin
      unique case (off)
        OffLed:    rdata_d[LedWidth-1:0] = led_q;
        OffCtrl:   rdata_d[0] = en_q;
        OffMtLo:   rdata_d = mtime_q[31:0];
        OffMtHi:   rdata_d = hi_rd;
        OffCmpLo:  rdata_d = cmp_q[31:0];
        OffCmpHi:  rdata_d = cmp_q[63:32];
        OffStatus: rdata_d[0] = irq_q;
        OffNone:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q    <= '0;
      en_q     <= 1'b0;
      mtime_q  <= '0;
      cmp_q    <= '1;
      presc_q  <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      led_q    <= led_d;
      en_q     <= en_d;
      mtime_q  <= mtime_d;
      cmp_q    <= cmp_d;
      presc_q  <= presc_d;
      irq_q    <= irq_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // A response still in flight when reset arrives is suppressed at once.
  assign gnt_o       = req_i;
  assign rvalid_o    = rvalid_q & ~rst_i;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign led_o       = led_q;
  assign irq_timer_o = irq_q;

endmodule
